// File: rtl/axis_window_accumulator.sv
// Sums the samples of each AXI-stream window (sow_i ... tlast) and emits the
// total as a single-beat result packet, with sticky overflow and a beat count.
module axis_window_accumulator #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned SIGNED     = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic                    s_axis_tlast,
  input  logic                    sow_i,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [ACC_WIDTH-1:0]    m_axis_tdata,
  output logic                    m_axis_tlast,
  output logic                    rts_o,
  output logic                    sow_o,
  output logic                    eow_o,
  output logic                    overflow_o,
  output logic [15:0]             beat_count_o
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH  = 16;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  // Bits above the sample width, filled when sign-extending a negative sample.
  localparam logic [ACC_WIDTH-1:0] EXT_MASK = {ACC_WIDTH{1'b1}} << DATA_WIDTH;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [ACC_WIDTH-1:0]  r_acc;
  logic [ACC_WIDTH-1:0]  w_acc_nxt;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [CNT_WIDTH-1:0]  w_count_nxt;
  logic                  r_ovf;
  logic                  w_ovf_nxt;
  logic                  r_tready;
  logic                  r_tvalid;
  logic                  r_sow;
  logic                  w_sow_nxt;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_masked;
  logic [ACC_WIDTH-1:0]  w_sample;
  logic [ACC_WIDTH-1:0]  w_sum;
  logic                  w_carry;
  logic                  w_sum_ovf;

  // Zero the bytes whose strobe is low.
  always_comb begin
    w_masked = '0;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      w_masked[i*8 +: 8] = s_axis_tstrb[i] ? s_axis_tdata[i*8 +: 8] : 8'h00;
    end
  end

  assign w_sample = ACC_WIDTH'(w_masked) |
                    (((SIGNED != 0) && w_masked[DATA_WIDTH-1]) ? EXT_MASK : '0);
  assign {w_carry, w_sum} = {1'b0, r_acc} + {1'b0, w_sample};
  assign w_sum_ovf = (SIGNED != 0)
                   ? ((r_acc[ACC_WIDTH-1] == w_sample[ACC_WIDTH-1]) &&
                      (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]))
                   : w_carry;
  assign w_accept = s_axis_tvalid & r_tready;

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_count_nxt = r_count;
    w_ovf_nxt   = r_ovf;
    w_sow_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_acc_nxt   = w_sample;
          w_count_nxt = CNT_WIDTH'(1);
          w_ovf_nxt   = 1'b0;
          w_sow_nxt   = 1'b1;
          w_state_nxt = s_axis_tlast ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (w_accept) begin
          if (sow_i) begin
            w_acc_nxt   = w_sample;
            w_count_nxt = CNT_WIDTH'(1);
            w_ovf_nxt   = 1'b0;
            w_sow_nxt   = 1'b1;
          end else begin
            w_acc_nxt   = w_sum;
            w_count_nxt = (r_count == {CNT_WIDTH{1'b1}}) ? r_count : r_count + CNT_WIDTH'(1);
            w_ovf_nxt   = r_ovf | w_sum_ovf;
          end
          if (s_axis_tlast) begin
            w_state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (m_axis_tready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_tready <= 1'b0;
      r_tvalid <= 1'b0;
      r_sow    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_acc    <= w_acc_nxt;
      r_count  <= w_count_nxt;
      r_ovf    <= w_ovf_nxt;
      r_tready <= (w_state_nxt != ST_HOLD);
      r_tvalid <= (w_state_nxt == ST_HOLD);
      r_sow    <= w_sow_nxt;
    end
  end

  assign s_axis_tready = r_tready;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tdata  = r_acc;
  assign m_axis_tlast  = r_tvalid;
  assign rts_o         = r_tvalid;
  assign sow_o         = r_sow;
  // Handoff pulse must coincide with the accepting cycle, so it is not registered.
  assign eow_o         = r_tvalid & m_axis_tready;
  assign overflow_o    = r_ovf;
  assign beat_count_o  = r_count;

endmodule

// File: doc/axis_window_accumulator.md
Name: axis_window_accumulator

Overview:
- Consumes an AXI-stream of DATA_WIDTH samples, one window per packet (first beat flagged by sow_i, last by s_axis_tlast).
- Sums every sample in the window and emits one ACC_WIDTH result beat per window on an AXI-stream master port.
- Sits directly downstream of axi_stream_generator_from_file and its sow edge-detect logic; it is the DUT slot of the accumulator bench.

Parameters:
- DATA_WIDTH, 8, sample width in bits; multiple of 8.
- ACC_WIDTH, 32, accumulator/result width; must be >= DATA_WIDTH.
- SIGNED, 0, 1 = samples and sum are two's complement; 0 = unsigned.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat ready.
- s_axis_tdata  in  DATA_WIDTH  sample.
- s_axis_tstrb  in  DATA_WIDTH/8  byte strobes; a byte with strobe 0 counts as zero.
- s_axis_tlast  in  1  last beat of window.
- sow_i  in  1  start-of-window marker, qualified by an accepted beat.
- m_axis_tvalid  out  1  result valid.
- m_axis_tready  in  1  result accepted by downstream.
- m_axis_tdata  out  ACC_WIDTH  window sum.
- m_axis_tlast  out  1  tied to m_axis_tvalid; every result is a single-beat packet.
- rts_o  out  1  ready-to-send; equals m_axis_tvalid.
- sow_o  out  1  one-cycle pulse: first beat of a window accepted.
- eow_o  out  1  one-cycle pulse: result handed off (m_axis_tvalid & m_axis_tready).
- overflow_o  out  1  sum of the current or held window wrapped; valid with m_axis_tvalid.
- beat_count_o  out  16  beats accepted in the current or held window; saturates at 0xFFFF.

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, acc=0, beat count=0. All outputs are 0 except s_axis_tready, which is 1 from the first cycle after reset release. Reset mid-window or while a result is held discards the window silently; no eow_o pulse is produced.
- Accepted beat: s_axis_tvalid & s_axis_tready. Sample value = tdata with strobed-off bytes zeroed, then sign-extended (SIGNED=1) or zero-extended to ACC_WIDTH.
- States:
  - IDLE: tready=1. An accepted beat sets acc=sample and count=1, and pulses sow_o the next cycle.
    - Window start is accepted whether or not sow_i is asserted; sow_i is informational in IDLE.
    - If the beat also has tlast: go to HOLD, else go to ACCUM.
  - ACCUM: tready=1. An accepted beat sets acc=acc+sample and count=count+1.
    - sow_i=1 on an accepted beat restarts the window instead: acc=sample, count=1, overflow cleared, sow_o pulses.
    - tlast on an accepted beat: go to HOLD.
  - HOLD: tready=0.
    - m_axis_tvalid=1 with m_axis_tdata=final acc; data stays stable while tvalid=1 and tready=0.
    - On m_axis_tready=1: eow_o pulses in that same cycle; next state IDLE with tvalid=0.
- Latency: m_axis_tvalid rises on the clock edge that accepts the tlast beat, i.e. visible the cycle after. Result throughput is at most one window per (N+1) cycles; there is exactly one bubble cycle per window.
- Overflow:
  - Unsigned: set on carry out of ACC_WIDTH.
  - Signed: set when both operands have the same sign and the result has a different sign.
  - Sticky within a window; the sum wraps modulo 2^ACC_WIDTH. Cleared on window start.
- Single-beat window (sow_i & tlast on the same beat): result = that sample, count = 1.
- tvalid low mid-window: the accumulator holds; no timeout.

Test Plan:
- Unsigned, 10 beats of 0x01..0x0A with sow_i on beat 1 and tlast on beat 10, m_axis_tready=1 → single result 0x37 one cycle after the last beat; beat_count_o=10; overflow_o=0; sow_o and eow_o each pulse once.
- Backpressure: same window with m_axis_tready held low for 5 cycles → tdata stays 0x37 and s_axis_tready stays 0 throughout; eow_o pulses on the cycle tready=1.
- ACC_WIDTH=8, unsigned, beats 0xFF,0x02 with tlast → tdata 0x01, overflow_o=1. SIGNED=1, DATA_WIDTH=8, beats 0x80,0xFF → tdata sign-extended sum 0xFFFFFF7F.
- Strobe: DATA_WIDTH=16, beats 0x1234 with tstrb=01, then 0x0100 with tstrb=11 and tlast → result 0x0134.
- Restart: sow_i asserted on beat 4 of a window of 0x10s, tlast on beat 6 → result 0x30, count 3, sow_o pulses twice.
- Reset mid-window after 3 beats, then a fresh window of 0x05,0x06 with tlast → result 0x0B; no stale result or eow_o pulse before it.
